exm_div_unit: RTL and testbench

Iterative, parametrised integer divider for the execute/memory stage. It replaces the single-cycle combinational divide path with a multi-cycle radix-2^UNROLL restoring divider. It has a valid/ready handshake on both sides, carries a destination tag, and can be flushed by branch mispredict. The EXM stage holds its instruction (drops `es_ready`) while this unit is busy and merges `result` into the write-back bus on `out_valid`.

---
 rtl/exm_pkg.sv | 37 +++
 rtl/exm_div_step.sv | 25 ++
 rtl/exm_div_unit.sv | 150 +++++++++++++++
 tb/tb_exm_div_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/exm_pkg.sv
// Shared definitions for the execute/memory stage divider: state encoding,
// width-dependent constants and the default forwarded tag width.
package exm_pkg;

  // Tag forwarded alongside a divide, e.g. {gr_we, dest}.
  localparam int FORWARD_TAG_W = 6;

  // Widest operand the constant helpers below can describe.
  localparam int MAX_WIDTH = 64;

  // Divider state encoding, kept as plain constants for older tools.
  typedef logic [1:0] div_state_t;
  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_CALC = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

  // Quotient returned for a divide by zero: all ones in the low 'width' bits.
  function automatic logic [MAX_WIDTH-1:0] div_zero_q(input int width);
    logic [MAX_WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) val[i] = 1'b1;
    end
    return val;
  endfunction

  // Most negative two's-complement value of 'width' bits.
  function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
    logic [MAX_WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i == width - 1) val[i] = 1'b1;
    end
    return val;
  endfunction

endpackage

// File: rtl/exm_div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // A trial subtraction without borrow means the divisor fits; the incoming
  // remainder is always below the divisor, so the kept result fits WIDTH+1 bits.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/exm_div_unit.sv
// Multi-cycle radix-2^UNROLL restoring divider for the execute/memory stage,
// with valid/ready handshakes, a pass-through tag and mispredict flush.
module exm_div_unit
  import exm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = FORWARD_TAG_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_unsigned,
  input  logic             use_mod,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int N     = WIDTH / UNROLL;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [MAX_WIDTH-1:0] ZERO_Q_FULL = div_zero_q(WIDTH);
  localparam logic [MAX_WIDTH-1:0] SMIN_FULL   = signed_min(WIDTH);
  localparam logic [WIDTH-1:0]     DIV_ZERO_Q  = ZERO_Q_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SIGNED_MIN  = SMIN_FULL[WIDTH-1:0];

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic             q_neg;
  logic             r_neg;
  logic             mod_q;

  logic                    dvd_neg;
  logic                    dsr_neg;
  logic [WIDTH-1:0]        dvd_abs;
  logic [WIDTH-1:0]        dsr_abs;
  logic                    is_div_zero;
  logic                    is_ovf;
  logic [WIDTH-1:0]        special_res;
  logic [UNROLL:0][WIDTH:0] rem_chain;
  logic [UNROLL-1:0]       q_vec;
  logic [WIDTH-1:0]        dvd_next;
  logic [WIDTH-1:0]        quo_fin;
  logic [WIDTH-1:0]        rem_fin;
  logic [WIDTH-1:0]        calc_res;

  // Handshake outputs decode the registered state; flush only ever gates them.
  assign in_ready  = (state == DIV_IDLE) && !flush;
  assign out_valid = (state == DIV_DONE) && !flush;
  assign busy      = (state != DIV_IDLE);

  // Operand magnitudes and special-case detection on the incoming request.
  always_comb begin
    dvd_neg     = ~is_unsigned & dividend[WIDTH-1];
    dsr_neg     = ~is_unsigned & divisor[WIDTH-1];
    dvd_abs     = dvd_neg ? -dividend : dividend;
    dsr_abs     = dsr_neg ? -divisor : divisor;
    is_div_zero = (divisor == '0);
    is_ovf      = ~is_unsigned && (dividend == SIGNED_MIN) && (divisor == DIV_ZERO_Q);
    if (is_div_zero) special_res = use_mod ? dividend : DIV_ZERO_Q;
    else             special_res = use_mod ? '0 : dividend;
  end

  assign rem_chain[0] = rem_q;

  // UNROLL restoring steps chained in series, consuming dividend bits MSB first.
  for (genvar j = 0; j < UNROLL; j++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_chain[j]),
      .dvd_bit (dvd_q[WIDTH-1-j]),
      .divisor (dsr_q),
      .rem_out (rem_chain[j+1]),
      .q_bit   (q_vec[UNROLL-1-j])
    );
  end

  // Quotient bits enter at the bottom as dividend bits leave at the top;
  // sign fix-up is modulo 2^WIDTH.
  always_comb begin
    dvd_next = (dvd_q << UNROLL) | WIDTH'(q_vec);
    quo_fin  = q_neg ? -dvd_next : dvd_next;
    rem_fin  = r_neg ? -rem_chain[UNROLL][WIDTH-1:0] : rem_chain[UNROLL][WIDTH-1:0];
    calc_res = mod_q ? rem_fin : quo_fin;
  end

  // Control FSM and datapath registers; flush outranks every other transition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= DIV_IDLE;
      count   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      mod_q   <= 1'b0;
      result  <= '0;
      out_tag <= '0;
    end else if (flush) begin
      state <= DIV_IDLE;
      count <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (in_valid) begin
            out_tag <= in_tag;
            mod_q   <= use_mod;
            if (is_div_zero || is_ovf) begin
              result <= special_res;
              state  <= DIV_DONE;
            end else begin
              rem_q <= '0;
              dvd_q <= dvd_abs;
              dsr_q <= dsr_abs;
              q_neg <= dvd_neg ^ dsr_neg;
              r_neg <= dvd_neg;
              count <= CNT_W'(N);
              state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_q <= rem_chain[UNROLL];
          dvd_q <= dvd_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            result <= calc_res;
            state  <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (out_ready) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exm_div_unit.sv
// Self-checking bench for exm_div_unit: directed cases plus randomized divides
// against an arithmetic reference, on a 32x1 and a 16x4 instance.
module tb_exm_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, flush;
  logic        in_valid, in_ready, is_unsigned, use_mod, out_valid, out_ready, busy;
  logic [31:0] dividend, divisor, result;
  logic [5:0]  in_tag, out_tag;

  logic        in_valid16, in_ready16, is_unsigned16, use_mod16, out_valid16, busy16;
  logic [15:0] dividend16, divisor16, result16;
  logic [5:0]  in_tag16, out_tag16;

  int vectors = 0;
  int miscompares = 0;

  exm_div_unit #(.WIDTH(32), .UNROLL(1), .TAG_W(6)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .is_unsigned(is_unsigned), .use_mod(use_mod), .dividend(dividend),
    .divisor(divisor), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag), .busy(busy)
  );

  exm_div_unit #(.WIDTH(16), .UNROLL(4), .TAG_W(6)) dut16 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid16), .in_ready(in_ready16),
    .is_unsigned(is_unsigned16), .use_mod(use_mod16), .dividend(dividend16),
    .divisor(divisor16), .in_tag(in_tag16), .flush(flush), .out_valid(out_valid16),
    .out_ready(1'b1), .result(result16), .out_tag(out_tag16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands as integers, truncated to w bits.
  function automatic logic [31:0] ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input bit uns, input bit mod);
    longint mask, sa, sb, q, r;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sb == 0) return mod ? 32'(sa) : 32'(mask);
    if (!uns) begin
      if (sa[w-1]) sa = sa - (longint'(1) << w);
      if (sb[w-1]) sb = sb - (longint'(1) << w);
    end
    q = sa / sb;
    r = sa % sb;
    return mod ? 32'(r & mask) : 32'(q & mask);
  endfunction

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit uns, input bit mod,
                       input logic [5:0] tag, input string name, output logic [31:0] got);
    logic [31:0] exp;
    int exp_lat, lat, n;
    exp = ref_div(32, a, b, uns, mod);
    exp_lat = (b == 0 || (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 32;
    dividend = a; divisor = b; is_unsigned = uns; use_mod = mod; in_tag = tag; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom; divisor = $urandom; in_tag = 6'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, result, exp);
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
    check({name, "_inrdy"}, 32'(in_ready), 32'd0);
    got = result;
    if (out_ready) begin
      @(posedge clk); #1;
      check({name, "_idle"}, {30'd0, out_valid, busy}, 32'd0);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit uns, input bit mod,
                       input logic [5:0] tag, input string name, output logic [15:0] got);
    logic [31:0] exp;
    int exp_lat, lat;
    exp = ref_div(16, {16'd0, a}, {16'd0, b}, uns, mod);
    exp_lat = (b == 0 || (!uns && a == 16'h8000 && b == 16'hFFFF)) ? 0 : 4;
    dividend16 = a; divisor16 = b; is_unsigned16 = uns; use_mod16 = mod; in_tag16 = tag;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 50) begin @(posedge clk); #1; lat++; end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, {16'd0, result16}, exp);
    check({name, "_tag"}, 32'(out_tag16), 32'(tag));
    got = result16;
    @(posedge clk); #1;
    check({name, "_idle"}, {31'd0, busy16}, 32'd0);
  endtask

  initial begin
    logic [31:0] got, a, b, exp;
    logic [15:0] got16, a16, b16;
    int stale;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    is_unsigned = 1'b0; use_mod = 1'b0; dividend = '0; divisor = '0; in_tag = '0;
    in_valid16 = 1'b0; is_unsigned16 = 1'b0; use_mod16 = 1'b0;
    dividend16 = '0; divisor16 = '0; in_tag16 = '0;
    #12;
    check("reset_ctl", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("reset_result", result, 32'd0);
    check("reset_tag", 32'(out_tag), 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // Flush blocks acceptance of a simultaneous request.
    flush = 1'b1; in_valid = 1'b1; dividend = 32'd9; divisor = 32'd3;
    #1 check("flush_inrdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1 check("flush_noaccept", {31'd0, busy}, 32'd0);

    // Directed values with hard-coded answers.
    run32(32'd100, 32'd7, 1'b0, 1'b0, 6'd5, "s100_7q", got);  check("plan_q14", got, 32'd14);
    run32(32'd100, 32'd7, 1'b0, 1'b1, 6'd6, "s100_7r", got);  check("plan_r2", got, 32'd2);
    run32(-32'sd7, 32'd2, 1'b0, 1'b0, 6'd7, "sm7_2q", got);   check("plan_m7q", got, 32'hFFFF_FFFD);
    run32(-32'sd7, 32'd2, 1'b0, 1'b1, 6'd8, "sm7_2r", got);   check("plan_m7r", got, 32'hFFFF_FFFF);
    run32(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 6'd9, "u_max_2", got); check("plan_umax", got, 32'h7FFF_FFFF);
    run32(32'd5, 32'd0, 1'b0, 1'b0, 6'd10, "dz_q", got);      check("plan_dzq", got, 32'hFFFF_FFFF);
    run32(32'd5, 32'd0, 1'b0, 1'b1, 6'd11, "dz_r", got);      check("plan_dzr", got, 32'd5);
    run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'd12, "ovf_q", got); check("plan_ovfq", got, 32'h8000_0000);
    run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 6'd13, "ovf_r", got); check("plan_ovfr", got, 32'd0);
    run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'd14, "u_minm1", got);

    // Back-pressure: result held while the consumer stalls.
    out_ready = 1'b0;
    exp = ref_div(32, 32'd1000, 32'd33, 1'b0, 1'b1);
    run32(32'd1000, 32'd33, 1'b0, 1'b1, 6'd33, "hold", got);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_ctl", {30'd0, out_valid, in_ready}, 32'b10);
      check("hold_res", result, exp);
      check("hold_tag", 32'(out_tag), 32'd33);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", {30'd0, out_valid, busy}, 32'd0);

    // Flush in the middle of an iteration, then a fresh request.
    dividend = 32'd100; divisor = 32'd7; is_unsigned = 1'b0; use_mod = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush_ov_comb", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {30'd0, out_valid, busy}, 32'd0);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("flush_stale", 32'(stale), 32'd0);
    run32(32'd12345, 32'd10, 1'b0, 1'b0, 6'd20, "post_flush", got);
    check("plan_1234", got, 32'd1234);

    // Asynchronous reset in the middle of an iteration.
    out_ready = 1'b0;
    dividend = 32'd777; divisor = 32'd5; in_tag = 6'd42; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("rst_ctl", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("rst_result", result, 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    @(negedge clk); resetn = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // Randomized 32-bit divides, biased toward corner operands.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run32(a, b, 1'($urandom), 1'($urandom), 6'($urandom), "rand32", got);
    end

    // Unrolled 16-bit instance.
    run16(16'd1000, 16'hFFFD, 1'b0, 1'b0, 6'd3, "s16_1000_m3", got16);
    check("plan16_m333", {16'd0, got16}, 32'h0000_FEB3);
    run16(16'h8000, 16'hFFFF, 1'b0, 1'b0, 6'd4, "s16_ovf", got16);
    for (int i = 0; i < 12; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 5) == 0) b16 = 16'd0;
      run16(a16, b16, 1'($urandom), 1'($urandom), 6'($urandom), "rand16", got16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
